// File: rtl/dram_pkg.sv
// rtl/dram_pkg.sv - shared DRAM request types and constants for the request arbiter
package dram_pkg;

   localparam int DRAM_ADDR_W = 27;
   localparam int DRAM_DATA_W = 128;

   localparam logic CMD_WRITE = 1'b0;
   localparam logic CMD_READ  = 1'b1;

   typedef struct packed {
      logic [DRAM_ADDR_W-1:0] addr;
      logic [DRAM_DATA_W-1:0] data;
      logic                   cmd;
   } dram_req_t;

   typedef enum logic {
      HOLD_EMPTY = 1'b0,
      HOLD_FULL  = 1'b1
   } hold_state_t;

endpackage

// File: rtl/dram_arb_id_fifo.sv
// rtl/dram_arb_id_fifo.sv - in-order FIFO of requester IDs for outstanding DRAM reads
module dram_arb_id_fifo #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 8
) (
   input  logic                     ui_clk,
   input  logic                     sys_rst_i,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap on their own
   always_ff @(posedge ui_clk or negedge sys_rst_i) begin
      if (!sys_rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge ui_clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/dram_req_arbiter.sv
// rtl/dram_req_arbiter.sv - round-robin arbiter sharing one DRAM controller port, in-order read return
// Optional per-requester grant/stall counters under `define DRAM_ARB_STATS_EN.
module dram_req_arbiter
   import dram_pkg::*;
#(
   parameter int NUM_REQ  = 2,
   parameter int ID_DEPTH = 8
) (
   input  logic                           ui_clk,
   input  logic                           sys_rst_i,
   input  logic [NUM_REQ-1:0]             req_en,
   output logic [NUM_REQ-1:0]             req_rdy,
   input  logic [NUM_REQ*DRAM_ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DRAM_DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]             req_cmd,
   output logic [NUM_REQ-1:0]             rsp_en,
   output logic [DRAM_DATA_W-1:0]         rsp_data,
   output logic                           dram_req_en,
   input  logic                           dram_req_rdy,
   output logic [DRAM_ADDR_W-1:0]         dram_req_addr,
   output logic [DRAM_DATA_W-1:0]         dram_req_data,
   output logic                           dram_req_cmd,
   input  logic                           dram_rsp_en,
   input  logic [DRAM_DATA_W-1:0]         dram_rsp_data,
   output logic                           err_unexp_rsp
`ifdef DRAM_ARB_STATS_EN
   ,
   output logic [NUM_REQ*32-1:0]          stat_grant,
   output logic [NUM_REQ*32-1:0]          stat_stall
`endif
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(ID_DEPTH) + 1;

   hold_state_t      state_q, state_d;
   dram_req_t        held_q;
   dram_req_t        winner_req;
   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] winner;
   logic             winner_vld;
   logic             can_load;
   logic             load;
   logic             id_push;
   logic             id_pop;
   logic [PTR_W-1:0] id_head;
   logic             id_full;
   logic             id_empty;
   logic [CNT_W-1:0] reads_pending;
   int               idx;

   // Round-robin search starting just after the last winner
   always_comb begin
      winner_vld = 1'b0;
      winner     = '0;
      idx        = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(ptr_q) + k) % NUM_REQ;
         if (!winner_vld && req_en[idx] &&
             (req_cmd[idx] == CMD_WRITE || reads_pending < CNT_W'(ID_DEPTH))) begin
            winner_vld = 1'b1;
            winner     = PTR_W'(idx);
         end
      end
   end

   assign can_load = (state_q == HOLD_EMPTY) || dram_req_rdy;

   always_comb begin
      req_rdy = '0;
      if (winner_vld && sys_rst_i) req_rdy[winner] = can_load;
   end

   assign load = |(req_en & req_rdy);

   always_comb begin
      winner_req.addr = req_addr[winner*DRAM_ADDR_W +: DRAM_ADDR_W];
      winner_req.data = req_data[winner*DRAM_DATA_W +: DRAM_DATA_W];
      winner_req.cmd  = req_cmd[winner];
   end

   always_comb begin
      state_d = state_q;
      if (load)
         state_d = HOLD_FULL;
      else if (state_q == HOLD_FULL && dram_req_rdy)
         state_d = HOLD_EMPTY;
   end

   always_ff @(posedge ui_clk or negedge sys_rst_i) begin
      if (!sys_rst_i) begin
         state_q <= HOLD_EMPTY;
         held_q  <= '0;
         ptr_q   <= PTR_W'(NUM_REQ - 1);
      end else begin
         state_q <= state_d;
         if (load) begin
            held_q <= winner_req;
            ptr_q  <= winner;
         end
      end
   end

   assign dram_req_en   = (state_q == HOLD_FULL);
   assign dram_req_addr = held_q.addr;
   assign dram_req_data = held_q.data;
   assign dram_req_cmd  = held_q.cmd;

   assign id_push = load && (winner_req.cmd == CMD_READ) && !id_full;
   assign id_pop  = dram_rsp_en && !id_empty;

   dram_arb_id_fifo #(
      .WIDTH (PTR_W),
      .DEPTH (ID_DEPTH)
   ) u_id_fifo (
      .ui_clk    (ui_clk),
      .sys_rst_i (sys_rst_i),
      .push      (id_push),
      .push_data (winner),
      .pop       (id_pop),
      .pop_data  (id_head),
      .full      (id_full),
      .empty     (id_empty),
      .count     (reads_pending)
   );

   // Responses return in issue order; the FIFO head names the owner
   always_ff @(posedge ui_clk or negedge sys_rst_i) begin
      if (!sys_rst_i) begin
         rsp_en        <= '0;
         rsp_data      <= '0;
         err_unexp_rsp <= 1'b0;
      end else begin
         rsp_en <= '0;
         if (id_pop) begin
            rsp_en   <= NUM_REQ'(1) << id_head;
            rsp_data <= dram_rsp_data;
         end
         if (dram_rsp_en && id_empty) err_unexp_rsp <= 1'b1;
      end
   end

`ifdef DRAM_ARB_STATS_EN
   always_ff @(posedge ui_clk or negedge sys_rst_i) begin
      if (!sys_rst_i) begin
         stat_grant <= '0;
         stat_stall <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_en[i] && req_rdy[i])
               stat_grant[i*32 +: 32] <= stat_grant[i*32 +: 32] + 32'd1;
            if (req_en[i] && !req_rdy[i])
               stat_stall[i*32 +: 32] <= stat_stall[i*32 +: 32] + 32'd1;
         end
      end
   end
`endif

endmodule
